// File: rtl/rf_port_arbiter.sv
// Two-requester arbiter sharing one single-port register file via an IDLE/SETUP/STROBE/DONE sequence.
// Define RFARB_ROUND_ROBIN_EN for round-robin on simultaneous requests; default is fixed priority to A.
module rf_port_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_a,
  input  logic              req_b,
  input  logic              we_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              done_a,
  output logic              done_b,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] rf_address,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              rf_reg_write,
  input  logic [DATA_W-1:0] rf_out,
  output logic [7:0]        txn_count
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;

  state_t              state, state_nxt;
  logic                we_l, we_l_nxt;
  logic                win_b;
  logic                gnt_a_nxt, gnt_b_nxt, done_a_nxt, done_b_nxt;
  logic                rf_reg_write_nxt;
  logic [ADDR_W-1:0]   rf_address_nxt;
  logic [DATA_W-1:0]   rf_write_data_nxt, rdata_nxt;
  logic [7:0]          txn_count_nxt;
`ifdef RFARB_ROUND_ROBIN_EN
  logic                last_b, last_b_nxt;
`endif

  // All outputs are flops so rf_reg_write cannot glitch and reset clears them at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      we_l          <= 1'b0;
      gnt_a         <= 1'b0;
      gnt_b         <= 1'b0;
      done_a        <= 1'b0;
      done_b        <= 1'b0;
      rf_reg_write  <= 1'b0;
      rf_address    <= '0;
      rf_write_data <= '0;
      rdata         <= '0;
      txn_count     <= 8'd0;
`ifdef RFARB_ROUND_ROBIN_EN
      last_b        <= 1'b1;
`endif
    end else begin
      state         <= state_nxt;
      we_l          <= we_l_nxt;
      gnt_a         <= gnt_a_nxt;
      gnt_b         <= gnt_b_nxt;
      done_a        <= done_a_nxt;
      done_b        <= done_b_nxt;
      rf_reg_write  <= rf_reg_write_nxt;
      rf_address    <= rf_address_nxt;
      rf_write_data <= rf_write_data_nxt;
      rdata         <= rdata_nxt;
      txn_count     <= txn_count_nxt;
`ifdef RFARB_ROUND_ROBIN_EN
      last_b        <= last_b_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_a || req_b) state_nxt = SETUP;
      SETUP:   state_nxt = we_l ? STROBE : DONE;
      STROBE:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef RFARB_ROUND_ROBIN_EN
  assign win_b = req_b && (!req_a || !last_b);
`else
  assign win_b = req_b && !req_a;
`endif

  // Computes next values for the registered outputs; the latched request lives in we_l/rf_address/rf_write_data.
  always_comb begin
    we_l_nxt          = we_l;
    gnt_a_nxt         = gnt_a;
    gnt_b_nxt         = gnt_b;
    done_a_nxt        = 1'b0;
    done_b_nxt        = 1'b0;
    rf_reg_write_nxt  = 1'b0;
    rf_address_nxt    = rf_address;
    rf_write_data_nxt = rf_write_data;
    rdata_nxt         = rdata;
    txn_count_nxt     = txn_count;
`ifdef RFARB_ROUND_ROBIN_EN
    last_b_nxt        = last_b;
`endif
    case (state)
      IDLE: begin
        if (req_a || req_b) begin
          gnt_a_nxt         = !win_b;
          gnt_b_nxt         = win_b;
          we_l_nxt          = win_b ? we_b : we_a;
          rf_address_nxt    = win_b ? addr_b : addr_a;
          rf_write_data_nxt = win_b ? wdata_b : wdata_a;
`ifdef RFARB_ROUND_ROBIN_EN
          last_b_nxt        = win_b;
`endif
        end
      end
      SETUP: begin
        if (we_l) begin
          rf_reg_write_nxt = 1'b1;
        end else begin
          rdata_nxt     = rf_out;
          done_a_nxt    = gnt_a;
          done_b_nxt    = gnt_b;
          txn_count_nxt = txn_count + 8'd1;
        end
      end
      STROBE: begin
        done_a_nxt    = gnt_a;
        done_b_nxt    = gnt_b;
        txn_count_nxt = txn_count + 8'd1;
      end
      DONE: begin
        gnt_a_nxt = 1'b0;
        gnt_b_nxt = 1'b0;
      end
      default: begin
        gnt_a_nxt = 1'b0;
        gnt_b_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Directed bench for rf_port_arbiter with a small register-file model; expectations follow
// RFARB_ROUND_ROBIN_EN if it is defined for the build.
module tb_rf_port_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_a, req_b, we_a, we_b;
  logic [1:0] addr_a, addr_b;
  logic [7:0] wdata_a, wdata_b;
  logic       gnt_a, gnt_b, done_a, done_b;
  logic [7:0] rdata;
  logic [1:0] rf_address;
  logic [7:0] rf_write_data;
  logic       rf_reg_write;
  logic [7:0] rf_out;
  logic [7:0] txn_count;

  int total = 0;
  int bad = 0;
  int overlap = 0;

  logic [7:0] mem [4];

  rf_port_arbiter #(.DATA_W(8), .ADDR_W(2)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .done_a(done_a), .done_b(done_b),
    .rdata(rdata), .rf_address(rf_address), .rf_write_data(rf_write_data),
    .rf_reg_write(rf_reg_write), .rf_out(rf_out), .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  // Register file model: combinational read, write on the strobe edge.
  assign rf_out = mem[rf_address];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= 8'h11;
      mem[1] <= 8'h22;
      mem[2] <= 8'h5A;
      mem[3] <= 8'h77;
    end else if (rf_reg_write) begin
      mem[rf_address] <= rf_write_data;
    end
  end

  always @(negedge clk) if (gnt_a && gnt_b) overlap++;

  typedef struct {
    logic       is_b;
    logic       we;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
    logic [7:0] exp_count;
    int         exp_lat;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, actual, actual, expected, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    int cyc = 0;
    int done_cyc = 0;
    int own_gnt = 0;
    int other_gnt = 0;
    int strobes = 0;
    int wrong_done = 0;
    int setup_addr = -1;
    int setup_wdata = -1;
    int setup_rw = -1;
    int seen_rdata = -1;
    int seen_count = -1;
    if (v.is_b) begin
      req_b = 1'b1; we_b = v.we; addr_b = v.addr; wdata_b = v.wdata;
    end else begin
      req_a = 1'b1; we_a = v.we; addr_a = v.addr; wdata_a = v.wdata;
    end
    while (cyc < 10) begin
      tick();
      cyc++;
      if (v.is_b ? gnt_b : gnt_a) own_gnt++;
      if (v.is_b ? gnt_a : gnt_b) other_gnt++;
      if (rf_reg_write) strobes++;
      if (v.is_b ? done_a : done_b) wrong_done++;
      if (cyc == 1) begin
        setup_addr = rf_address; setup_wdata = rf_write_data; setup_rw = rf_reg_write;
      end
      if (v.is_b ? done_b : done_a) begin
        done_cyc = cyc; seen_rdata = rdata; seen_count = txn_count;
        break;
      end
    end
    req_a = 1'b0; req_b = 1'b0;
    tick();
    checkOutput($sformatf("v%0d latency", idx), done_cyc, v.exp_lat);
    checkOutput($sformatf("v%0d gnt_cycles", idx), own_gnt, v.exp_lat);
    checkOutput($sformatf("v%0d other_gnt", idx), other_gnt, 0);
    checkOutput($sformatf("v%0d strobes", idx), strobes, v.we ? 1 : 0);
    checkOutput($sformatf("v%0d wrong_done", idx), wrong_done, 0);
    checkOutput($sformatf("v%0d rdata", idx), seen_rdata, v.exp_rdata);
    checkOutput($sformatf("v%0d txn_count", idx), seen_count, v.exp_count);
    checkOutput($sformatf("v%0d idle_gnt", idx), gnt_a | gnt_b, 0);
    if (v.we) begin
      checkOutput($sformatf("v%0d setup_addr", idx), setup_addr, v.addr);
      checkOutput($sformatf("v%0d setup_wdata", idx), setup_wdata, v.wdata);
      checkOutput($sformatf("v%0d setup_rw", idx), setup_rw, 0);
    end
  endtask

  initial begin
    int n;
    int found;
    int last_cyc;
    int cyc;
    int cnt255;
    int stray;
    logic [7:0] exp_w;

    vecs[0] = '{is_b:1'b0, we:1'b0, addr:2'd2, wdata:8'h00, exp_rdata:8'h5A, exp_count:8'd1, exp_lat:2};
    vecs[1] = '{is_b:1'b1, we:1'b1, addr:2'd3, wdata:8'hC3, exp_rdata:8'h5A, exp_count:8'd2, exp_lat:3};
    vecs[2] = '{is_b:1'b0, we:1'b0, addr:2'd3, wdata:8'h00, exp_rdata:8'hC3, exp_count:8'd3, exp_lat:2};
    vecs[3] = '{is_b:1'b1, we:1'b0, addr:2'd0, wdata:8'h00, exp_rdata:8'h11, exp_count:8'd4, exp_lat:2};
    vecs[4] = '{is_b:1'b0, we:1'b1, addr:2'd1, wdata:8'h9E, exp_rdata:8'h11, exp_count:8'd5, exp_lat:3};
    vecs[5] = '{is_b:1'b1, we:1'b0, addr:2'd1, wdata:8'h00, exp_rdata:8'h9E, exp_count:8'd6, exp_lat:2};

    req_a = 0; req_b = 0; we_a = 0; we_b = 0;
    addr_a = 0; addr_b = 0; wdata_a = 0; wdata_b = 0;
    rst = 1'b1;
    #3;
    checkOutput("reset gnt", {30'd0, gnt_a, gnt_b}, 0);
    checkOutput("reset done", {30'd0, done_a, done_b}, 0);
    checkOutput("reset rf_reg_write", rf_reg_write, 0);
    checkOutput("reset rf_address", rf_address, 0);
    checkOutput("reset rf_write_data", rf_write_data, 0);
    checkOutput("reset rdata", rdata, 0);
    checkOutput("reset txn_count", txn_count, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) applyStimulus(vecs[i], i);
    checkOutput("idle holds rf_address", rf_address, 1);

    // Both requesters held high together for four back-to-back reads.
    $display("[TB] simultaneous requests");
    req_a = 1; req_b = 1; we_a = 0; we_b = 0; addr_a = 2'd0; addr_b = 2'd1;
    n = 0; last_cyc = 0; cyc = 0;
    while (cyc < 40 && n < 4) begin
      tick();
      cyc++;
      if (done_a || done_b) begin
`ifdef RFARB_ROUND_ROBIN_EN
        exp_w = (n % 2 == 1) ? 8'd1 : 8'd0;
`else
        exp_w = 8'd0;
`endif
        checkOutput($sformatf("simul winner%0d", n), done_b, exp_w);
        if (n > 0) checkOutput($sformatf("simul period%0d", n), cyc - last_cyc, 3);
        last_cyc = cyc;
        n++;
      end
    end
    req_a = 0; req_b = 0;
    checkOutput("simul count", n, 4);
    tick();

    // Reset during the write strobe must drop everything immediately.
    $display("[TB] reset during strobe");
    req_b = 1; we_b = 1; addr_b = 2'd0; wdata_b = 8'h44;
    found = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (rf_reg_write) begin
        found = 1;
        break;
      end
    end
    checkOutput("strobe seen", found, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst rf_reg_write", rf_reg_write, 0);
    checkOutput("rst gnt_b", gnt_b, 0);
    checkOutput("rst done_b", done_b, 0);
    checkOutput("rst txn_count", txn_count, 0);
    req_b = 0;
    #3 rst = 1'b0;
    stray = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (done_a || done_b || gnt_a || gnt_b || rf_reg_write) stray++;
    end
    checkOutput("post-rst activity", stray, 0);
    checkOutput("post-rst txn_count", txn_count, 0);

    // 256 back-to-back reads wrap the counter.
    $display("[TB] counter wrap");
    req_a = 1; we_a = 0; addr_a = 2'd2;
    n = 0; cnt255 = -1;
    for (int c = 0; c < 900; c++) begin
      tick();
      if (done_a) begin
        n++;
        if (n == 255) cnt255 = txn_count;
        if (n == 256) break;
      end
    end
    checkOutput("wrap done count", n, 256);
    checkOutput("wrap at 255", cnt255, 255);
    checkOutput("wrap to 0", txn_count, 0);
    req_a = 0;
    tick();
    checkOutput("gnt overlap", overlap, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rf_port_arbiter.md
RF_PORT_ARBITER -- requirements
Module: rf_port_arbiter

Interface
REQ-001 Parameter DATA_W, default 8, register data width.
REQ-002 Parameter ADDR_W, default 2, register address width (4 registers).
REQ-003 Port clk  input  1  rising-edge clock.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Ports req_a / req_b  input  1  access request from datapath (A) / debug-loader (B).
REQ-006 Ports we_a / we_b  input  1  1 = write, 0 = read; valid while req is high.
REQ-007 Ports addr_a / addr_b  input  ADDR_W  target register.
REQ-008 Ports wdata_a / wdata_b  input  DATA_W  write data.
REQ-009 Ports gnt_a / gnt_b  output  1  high for the whole transaction owned by that requester.
REQ-010 Ports done_a / done_b  output  1  one-cycle completion pulse.
REQ-011 Port rdata  output  DATA_W  registered read result, shared by both requesters.
REQ-012 Ports rf_address  output  ADDR_W; rf_write_data  output  DATA_W; rf_reg_write  output  1: drive the single-port register file.
REQ-013 Port rf_out  input  DATA_W  register file combinational read data.
REQ-014 Port txn_count  output  8  completed-transaction counter.

Function
REQ-015 FSM states IDLE, SETUP, STROBE, DONE; req inputs are sampled only in IDLE.
REQ-016 IDLE with any req high: select winner, latch we/addr/wdata, assert its gnt, go to SETUP next cycle.
REQ-017 SETUP: rf_address/rf_write_data driven from latched values, rf_reg_write low; a read goes to DONE and captures rf_out into rdata on the SETUP->DONE edge; a write goes to STROBE.
REQ-018 STROBE (writes only): rf_reg_write high for exactly one cycle with address/data unchanged; then DONE.
REQ-019 DONE: winner's done pulses high one cycle, gnt stays high, txn_count increments (wraps 255->0); next state IDLE.
REQ-020 Latency from req sampled high in IDLE to done: read 2 cycles, write 3 cycles; back-to-back issue every 3 (read) / 4 (write) cycles.
REQ-021 rf_reg_write SHALL be low in every state except STROBE and SHALL never glitch (registered output).
REQ-022 rf_address and rf_write_data SHALL hold their last values in IDLE.
REQ-023 Requester holds req/we/addr/wdata stable until done; it deasserts req on the edge where it observes done, otherwise a new transaction is started.
REQ-024 gnt_a and gnt_b SHALL never be high simultaneously; only the owner's done pulses.
REQ-025 rdata updates only on completed reads; writes leave rdata unchanged.
REQ-026 Request arriving while busy is ignored until IDLE; no queuing.

Reset
REQ-027 rst asserted: state IDLE, gnt_a=gnt_b=0, done_a=done_b=0, rf_reg_write=0, rf_address=0, rf_write_data=0, rdata=0, txn_count=0, last-served pointer = B, all immediately without clock.
REQ-028 Reset mid-transaction aborts it with no done pulse and no further rf_reg_write; a rst during STROBE drops rf_reg_write at once.
REQ-029 The block does not drive the register file's own reset.

Configuration
REQ-030 Macro RFARB_ROUND_ROBIN_EN defined: simultaneous requests in IDLE go to the requester not last served; single request always granted.
REQ-031 Macro undefined: fixed priority, A always wins simultaneous requests; last-served pointer unused.

Verification
REQ-032 Reset, then req_a read addr 2 with rf_out=8'h5A -> gnt_a 2 cycles, done_a at cycle 2, rdata=8'h5A, txn_count=1, rf_reg_write never high.
REQ-033 req_b write addr 3 data 8'hC3 -> rf_address=3, rf_write_data=8'hC3 in SETUP, rf_reg_write high exactly one cycle, done_b at cycle 3, rdata unchanged.
REQ-034 req_a and req_b held high together for 4 transactions -> with RFARB_ROUND_ROBIN_EN grants A,B,A,B; without it A,A,A,A.
REQ-035 rst asserted during STROBE of a write -> rf_reg_write, gnt, done drop immediately; after release IDLE, txn_count=0, no done pulse.
REQ-036 256 completed reads -> txn_count wraps to 0; gnt_a and gnt_b never high together throughout.
